stream_packer: RTL and testbench
================================

STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 Parameter IN_W, default 8: input lane width in bits.
REQ-002 Parameter RATIO, default 4: lanes per output word; OUT_W = IN_W*RATIO.
REQ-003 Parameter FLUSH_GAP, default 16: consecutive idle cycles that force flush of a partial word; 0 disables gap flush.
REQ-004 Parameter MSB_FIRST, default 0: 0 places the first lane at bits [IN_W-1:0], 1 places it at the top lane.
REQ-005 Ports are: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 valid_in input 1: data_in qualifier; no backpressure on the input side.
REQ-007 data_in input IN_W: input lane.
REQ-008 flush input 1: force emission of the current partial word.
REQ-009 clr_ovf input 1: clear the sticky overflow flag.
REQ-010 valid_out output 1; ready_out input 1; data_out output OUT_W: output word, valid/ready handshake.
REQ-011 keep_out output RATIO: per-lane valid mask for data_out, indexed by lane arrival order.
REQ-012 last_out output 1: word was terminated by flush or gap rather than by filling.
REQ-013 overflow output 1: sticky flag, set when a word was dropped.

Function
REQ-014 Lane counter 0..RATIO-1 advances on each valid_in cycle; lane k goes to [k*IN_W +: IN_W] (MSB_FIRST=0) or [(RATIO-1-k)*IN_W +: IN_W] (MSB_FIRST=1).
REQ-015 On acceptance of lane RATIO-1, the word is pushed with keep_out all ones and last_out=0, and the counter wraps to 0.
REQ-016 Flush event = flush=1, or gap counter reaching FLUSH_GAP, while the accumulator holds at least 1 lane.
REQ-017 A flush event pushes a word with unfilled lanes zero, keep_out set only for filled lanes, and last_out=1; the counter returns to 0.
REQ-018 When flush and valid_in occur in the same cycle, data_in is included first, then the word is flushed; if that lane completes the word, one word is pushed with last_out=1.
REQ-019 flush with an empty accumulator, and gap expiry with an empty accumulator, produce no word.
REQ-020 Gap counter is cleared by valid_in and whenever the accumulator is empty; it increments on idle cycles with a partial word and saturates at FLUSH_GAP.
REQ-021 Pushed words enter a 2-entry output FIFO; valid_out = FIFO non-empty; a pop occurs on valid_out & ready_out.
REQ-022 Latency: valid_out rises the cycle after the completing lane is accepted, when the FIFO was empty.
REQ-023 A simultaneous push and pop on a full FIFO is accepted without loss.
REQ-024 A push to a full FIFO without a pop drops the word, sets overflow, and still resets the accumulator.
REQ-025 data_out, keep_out and last_out hold stable while valid_out=1 and ready_out=0.
REQ-026 clr_ovf clears overflow; a drop in the same cycle as clr_ovf wins, so overflow stays 1.

Reset
REQ-027 On rst_n low, asynchronously: valid_out=0, data_out=0, keep_out=0, last_out=0, overflow=0; lane counter, gap counter and FIFO are emptied.
REQ-028 Reset mid-word discards the partial word, and no flush is emitted after release.
REQ-029 First valid_in sampled after rst_n deasserts is lane 0.

Structure
REQ-030 Shared package stream_pack_pkg holds default IN_W/RATIO/FLUSH_GAP constants and a function computing clog2 widths for the counters.
REQ-031 Elaboration rejects RATIO<2 and IN_W<1.
REQ-032 One sub-module, pack_out_fifo: 2-entry FIFO of {last, keep, data}, same clk/rst_n.
REQ-033 Accumulator, lane counter and gap counter live in stream_packer.

Verification
REQ-034 Defaults, ready_out=1, bytes 11,22,33,44 on consecutive cycles -> one word 44332211, keep 1111, last 0, one cycle after the 44 byte.
REQ-035 MSB_FIRST=1, same bytes -> 11223344.
REQ-036 Bytes AA,BB, then 16 idle cycles -> word 0000BBAA, keep 0011, last 1; no further word after more idle.
REQ-037 Byte 01 with flush=1 in the same cycle -> 00000001, keep 0001, last 1. Flush alone while empty -> no word.
REQ-038 ready_out=0, 3 full words sent -> first 2 held stable, third dropped, overflow=1. clr_ovf -> overflow=0.
REQ-039 rst_n pulsed low after 2 bytes, then 4 bytes 01..04 -> exactly one word 04030201.

Source files
------------

// File: rtl/stream_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pack_pkg
// Purpose  : Shared constants and helpers for the stream packer slice.
//            Holds the default lane width, lanes-per-word ratio and idle-gap
//            flush threshold, plus a width helper for the counters.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package stream_pack_pkg;

    localparam int DEFAULT_IN_W      = 8;
    localparam int DEFAULT_RATIO     = 4;
    localparam int DEFAULT_FLUSH_GAP = 16;

    // Bits needed to hold values 0..n-1 (never less than 1).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stream_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_packer_if
// Purpose  : Bundles the lane input side and the word output handshake of
//            the stream packer.
// Ports    : valid_in/data_in   - input lane (no backpressure)
//            flush/clr_ovf      - partial-word flush, sticky overflow clear
//            valid_out/ready_out/data_out/keep_out/last_out - output word
//            overflow           - sticky word-dropped flag
//            modport slave  : packer side
//            modport master : producer/consumer side
// Revision : 1.0 - initial release
// ============================================================================
interface stream_packer_if
    import stream_pack_pkg::*;
#(
    parameter int IN_W  = DEFAULT_IN_W,
    parameter int RATIO = DEFAULT_RATIO
);
    localparam int OUT_W = IN_W * RATIO;

    logic             valid_in;
    logic [IN_W-1:0]  data_in;
    logic             flush;
    logic             clr_ovf;
    logic             valid_out;
    logic             ready_out;
    logic [OUT_W-1:0] data_out;
    logic [RATIO-1:0] keep_out;
    logic             last_out;
    logic             overflow;

    modport slave (
        input  valid_in, data_in, flush, clr_ovf, ready_out,
        output valid_out, data_out, keep_out, last_out, overflow
    );

    modport master (
        output valid_in, data_in, flush, clr_ovf, ready_out,
        input  valid_out, data_out, keep_out, last_out, overflow
    );

endinterface

`default_nettype wire

// File: rtl/stream_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pack_out_fifo
// Purpose  : Two-entry output FIFO holding {last, keep, data} words.
//            Head entry is driven straight from storage so it stays stable
//            while the consumer stalls. A push while full is only written
//            when a pop frees the head slot in the same cycle.
// Ports    : clk, rst_n  - clock, asynchronous active-low reset
//            push_i/data_i - write request and entry
//            pop_i         - remove head entry
//            full_o        - both entries occupied
//            valid_o/data_o- head entry present / head entry
// Revision : 1.0 - initial release
// ============================================================================
module pack_out_fifo
    import stream_pack_pkg::*;
#(
    parameter int W = 37
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         push_i,
    input  wire logic [W-1:0] data_i,
    input  wire logic         pop_i,
    output logic              full_o,
    output logic              valid_o,
    output logic [W-1:0]      data_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_q;
    logic         rd_q;
    logic [1:0]   cnt_q;
    logic [1:0]   cnt_d;
    logic         w_wr;
    logic         w_rd;

    assign full_o  = (cnt_q == 2'd2);
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_q];

    // On a full FIFO the write slot equals the head slot; writing it is safe
    // only because that head is leaving in the same cycle.
    assign w_wr = push_i && (!full_o || pop_i);
    assign w_rd = pop_i && valid_o;

    always_comb begin
        cnt_d = cnt_q;
        if (w_wr && !w_rd) begin
            cnt_d = cnt_q + 2'd1;
        end else if (w_rd && !w_wr) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            if (w_wr) begin
                mem_q[wr_q] <= data_i;
            end
            wr_q  <= wr_q ^ w_wr;
            rd_q  <= rd_q ^ w_rd;
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : stream_packer
// Purpose  : Packs RATIO narrow lanes of IN_W bits into one OUT_W word.
//            Full words are pushed with keep all ones; partial words are
//            pushed on an explicit flush or after FLUSH_GAP idle cycles with
//            last set and keep marking the filled lanes. Words queue in a
//            two-entry FIFO; a word pushed into a full FIFO without a pop is
//            dropped and raises the sticky overflow flag.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - stream_packer_if.slave (lane input, word output,
//                     flush, clr_ovf, overflow)
// Revision : 1.0 - initial release
// ============================================================================
module stream_packer
    import stream_pack_pkg::*;
#(
    parameter int IN_W      = DEFAULT_IN_W,
    parameter int RATIO     = DEFAULT_RATIO,
    parameter int FLUSH_GAP = DEFAULT_FLUSH_GAP,
    parameter bit MSB_FIRST = 1'b0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    stream_packer_if.slave  bus
);

    localparam int c_out_w  = IN_W * RATIO;
    localparam int c_cnt_w  = cnt_width(RATIO);
    localparam int c_fill_w = cnt_width(RATIO + 1);
    localparam int c_gap_w  = cnt_width(FLUSH_GAP + 1);
    localparam int c_ent_w  = 1 + RATIO + c_out_w;
    localparam logic [c_gap_w:0] c_gap_lim = (c_gap_w + 1)'(FLUSH_GAP);

    generate
        if (RATIO < 2 || IN_W < 1) begin : g_bad_params
            $error("stream_packer: RATIO must be >= 2 and IN_W >= 1");
        end
    endgenerate

    logic [c_out_w-1:0]  acc_q,  acc_d;
    logic [c_cnt_w-1:0]  lane_q, lane_d;
    logic [c_gap_w-1:0]  gap_q,  gap_d;
    logic                ovf_q,  ovf_d;

    logic [c_out_w-1:0]  w_acc_ins;
    logic [c_fill_w-1:0] w_fill;
    logic [c_gap_w:0]    w_gap_next;
    logic                w_full;
    logic                w_gap_hit;
    logic                w_flush_evt;
    logic                w_push;
    logic [RATIO-1:0]    w_keep;
    logic                w_fifo_full;
    logic                w_fifo_valid;
    logic                w_pop;
    logic                w_drop;
    logic [c_ent_w-1:0]  w_head;

    // Accumulator with the current lane merged in. Unfilled lanes are zero
    // because the accumulator is cleared on every push and at reset.
    always_comb begin
        w_acc_ins = acc_q;
        for (int k = 0; k < RATIO; k++) begin
            if (bus.valid_in && (lane_q == c_cnt_w'(k))) begin
                w_acc_ins[(MSB_FIRST ? (RATIO - 1 - k) : k) * IN_W +: IN_W] = bus.data_in;
            end
        end
    end

    // Lanes held once this cycle's input is included.
    assign w_fill = c_fill_w'(lane_q) + c_fill_w'(bus.valid_in);
    assign w_full = bus.valid_in && (lane_q == c_cnt_w'(RATIO - 1));

    // Gap expiry fires on the idle cycle whose increment reaches FLUSH_GAP.
    assign w_gap_next = {1'b0, gap_q} + {{c_gap_w{1'b0}}, 1'b1};
    assign w_gap_hit  = (FLUSH_GAP != 0) && !bus.valid_in && (lane_q != '0)
                        && (w_gap_next >= c_gap_lim);

    // Flush (explicit or gap) only matters with something in the accumulator;
    // when it coincides with the completing lane the single word gets last=1.
    assign w_flush_evt = (bus.flush || w_gap_hit) && (w_fill != '0);
    assign w_push      = w_full || w_flush_evt;

    always_comb begin
        w_keep = '0;
        for (int k = 0; k < RATIO; k++) begin
            w_keep[k] = (c_fill_w'(k) < w_fill);
        end
    end

    assign w_pop  = w_fifo_valid && bus.ready_out;
    assign w_drop = w_push && w_fifo_full && !w_pop;

    always_comb begin
        acc_d  = w_push ? '0 : w_acc_ins;
        lane_d = w_push ? '0 : w_fill[c_cnt_w-1:0];

        gap_d = gap_q;
        if (bus.valid_in || w_push || (lane_q == '0)) begin
            gap_d = '0;
        end else if (w_gap_next <= c_gap_lim) begin
            gap_d = w_gap_next[c_gap_w-1:0];
        end

        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (w_drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            lane_q <= '0;
            gap_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            lane_q <= lane_d;
            gap_q  <= gap_d;
            ovf_q  <= ovf_d;
        end
    end

    pack_out_fifo #(
        .W (c_ent_w)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (w_push),
        .data_i  ({w_flush_evt, w_keep, w_acc_ins}),
        .pop_i   (w_pop),
        .full_o  (w_fifo_full),
        .valid_o (w_fifo_valid),
        .data_o  (w_head)
    );

    assign bus.valid_out = w_fifo_valid;
    assign bus.last_out  = w_head[c_ent_w-1];
    assign bus.keep_out  = w_head[c_out_w +: RATIO];
    assign bus.data_out  = w_head[c_out_w-1:0];
    assign bus.overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_stream_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_packer
// Purpose  : Directed self-checking bench for stream_packer. Two instances
//            share the same input stimulus: one LSB-first, one MSB-first
//            (the latter always ready, only its packing order is checked).
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_packer;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;
    int seen;

    stream_packer_if #(.IN_W(8), .RATIO(4)) bus0 ();
    stream_packer_if #(.IN_W(8), .RATIO(4)) bus1 ();

    stream_packer #(
        .IN_W(8), .RATIO(4), .FLUSH_GAP(16), .MSB_FIRST(1'b0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    stream_packer #(
        .IN_W(8), .RATIO(4), .FLUSH_GAP(16), .MSB_FIRST(1'b1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    assign bus1.valid_in  = bus0.valid_in;
    assign bus1.data_in   = bus0.data_in;
    assign bus1.flush     = bus0.flush;
    assign bus1.clr_ovf   = bus0.clr_ovf;
    assign bus1.ready_out = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts cycles with a word presented over n cycles.
    task automatic idle_watch(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus0.valid_out) cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus0.valid_in  = 1'b0;
        bus0.data_in   = 8'h00;
        bus0.flush     = 1'b0;
        bus0.clr_ovf   = 1'b0;
        bus0.ready_out = 1'b1;
        repeat (3) tick();

        // Reset state
        check_eq("rst_valid", 64'(bus0.valid_out), 64'h0);
        check_eq("rst_data",  64'(bus0.data_out),  64'h0);
        check_eq("rst_keep",  64'(bus0.keep_out),  64'h0);
        check_eq("rst_last",  64'(bus0.last_out),  64'h0);
        check_eq("rst_ovf",   64'(bus0.overflow),  64'h0);
        rst_n = 1'b1;
        tick();

        // Full word, both lane orders
        bus0.valid_in = 1'b1;
        bus0.data_in = 8'h11; tick();
        bus0.data_in = 8'h22; tick();
        bus0.data_in = 8'h33; tick();
        check_eq("full_not_early", 64'(bus0.valid_out), 64'h0);
        bus0.data_in = 8'h44; tick();
        bus0.valid_in = 1'b0;
        check_eq("full_valid", 64'(bus0.valid_out), 64'h1);
        check_eq("full_data",  64'(bus0.data_out),  64'h44332211);
        check_eq("full_keep",  64'(bus0.keep_out),  64'hF);
        check_eq("full_last",  64'(bus0.last_out),  64'h0);
        check_eq("msb_valid",  64'(bus1.valid_out), 64'h1);
        check_eq("msb_data",   64'(bus1.data_out),  64'h11223344);
        tick();
        check_eq("full_popped", 64'(bus0.valid_out), 64'h0);

        // Gap flush of a two-lane partial word
        bus0.valid_in = 1'b1;
        bus0.data_in = 8'hAA; tick();
        bus0.data_in = 8'hBB; tick();
        bus0.valid_in = 1'b0;
        repeat (15) tick();
        check_eq("gap_not_early", 64'(bus0.valid_out), 64'h0);
        idle_watch(2, seen);
        check_eq("gap_word_seen", 64'(seen), 64'h1);
        // Consumer always ready: word shows for exactly one cycle, re-present it
        // by stalling is not possible here, so check content on a fresh run below.
        bus0.ready_out = 1'b0;
        bus0.valid_in = 1'b1;
        bus0.data_in = 8'hAA; tick();
        bus0.data_in = 8'hBB; tick();
        bus0.valid_in = 1'b0;
        repeat (16) tick();
        check_eq("gap_valid", 64'(bus0.valid_out), 64'h1);
        check_eq("gap_data",  64'(bus0.data_out),  64'h0000BBAA);
        check_eq("gap_keep",  64'(bus0.keep_out),  64'h3);
        check_eq("gap_last",  64'(bus0.last_out),  64'h1);
        bus0.ready_out = 1'b1;
        idle_watch(25, seen);
        check_eq("gap_no_extra", 64'(seen), 64'h0);

        // Flush together with a lane, then flush while empty
        bus0.valid_in = 1'b1; bus0.data_in = 8'h01; bus0.flush = 1'b1;
        bus0.ready_out = 1'b0;
        tick();
        bus0.valid_in = 1'b0; bus0.flush = 1'b0;
        check_eq("fl_valid", 64'(bus0.valid_out), 64'h1);
        check_eq("fl_data",  64'(bus0.data_out),  64'h00000001);
        check_eq("fl_keep",  64'(bus0.keep_out),  64'h1);
        check_eq("fl_last",  64'(bus0.last_out),  64'h1);
        bus0.ready_out = 1'b1;
        tick();
        check_eq("fl_popped", 64'(bus0.valid_out), 64'h0);
        bus0.flush = 1'b1; tick();
        bus0.flush = 1'b0;
        check_eq("fl_empty_now", 64'(bus0.valid_out), 64'h0);
        idle_watch(3, seen);
        check_eq("fl_empty_none", 64'(seen), 64'h0);

        // Stalled consumer: two held, third dropped
        bus0.ready_out = 1'b0;
        bus0.valid_in  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus0.data_in = 8'(8'h10 + i);
            tick();
            if (i == 8) check_eq("ovf_hold_mid", 64'(bus0.data_out), 64'h13121110);
        end
        bus0.valid_in = 1'b0;
        check_eq("ovf_valid", 64'(bus0.valid_out), 64'h1);
        check_eq("ovf_data",  64'(bus0.data_out),  64'h13121110);
        check_eq("ovf_keep",  64'(bus0.keep_out),  64'hF);
        check_eq("ovf_last",  64'(bus0.last_out),  64'h0);
        check_eq("ovf_flag",  64'(bus0.overflow),  64'h1);
        tick();
        check_eq("ovf_hold_end", 64'(bus0.data_out), 64'h13121110);
        bus0.clr_ovf = 1'b1; tick();
        bus0.clr_ovf = 1'b0;
        check_eq("ovf_cleared", 64'(bus0.overflow), 64'h0);
        bus0.ready_out = 1'b1;
        tick();
        check_eq("ovf_second", 64'(bus0.data_out), 64'h17161514);
        tick();
        check_eq("ovf_drained", 64'(bus0.valid_out), 64'h0);

        // Push and pop in the same cycle on a full FIFO
        bus0.ready_out = 1'b0;
        bus0.valid_in  = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus0.data_in = 8'(8'h20 + i);
            tick();
        end
        bus0.data_in = 8'h2B; bus0.ready_out = 1'b1;
        tick();
        bus0.valid_in = 1'b0; bus0.ready_out = 1'b0;
        check_eq("pp_no_ovf", 64'(bus0.overflow), 64'h0);
        check_eq("pp_head",   64'(bus0.data_out), 64'h27262524);
        bus0.ready_out = 1'b1;
        tick();
        check_eq("pp_third", 64'(bus0.data_out), 64'h2B2A2928);
        check_eq("pp_keep",  64'(bus0.keep_out), 64'hF);
        tick();
        check_eq("pp_drained", 64'(bus0.valid_out), 64'h0);

        // Reset mid-word discards the partial
        bus0.valid_in = 1'b1;
        bus0.data_in = 8'h55; tick();
        bus0.data_in = 8'h66; tick();
        bus0.valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(bus0.valid_out), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        bus0.valid_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus0.data_in = 8'(i);
            tick();
        end
        bus0.valid_in = 1'b0;
        check_eq("mid_rst_valid2", 64'(bus0.valid_out), 64'h1);
        check_eq("mid_rst_data",   64'(bus0.data_out),  64'h04030201);
        idle_watch(25, seen);
        check_eq("mid_rst_no_more", 64'(seen), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
